// File: rtl/first_nios2_system_sysid_probe_pkg.sv
// Shared definitions for the system-ID probe: FSM encoding, sysid word addresses and defaults.
package first_nios2_system_sysid_probe_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ID,
      ST_WAIT_ID,
      ST_RD_TS,
      ST_WAIT_TS,
      ST_DONE
   } state_t;

   localparam logic        SYSID_ADDR_ID              = 1'b0;
   localparam logic        SYSID_ADDR_TS              = 1'b1;
   localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1455298001;

   // Wide enough for the largest timeout (65535) and the read latency.
   localparam int CNT_W = 16;

endpackage

// File: rtl/first_nios2_system_sysid_probe_if.sv
// Avalon-MM read-only link between the probe (master) and the sysid control slave.
interface first_nios2_system_sysid_probe_if;
   logic        address;
   logic        read;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (output address, read, input waitrequest, readdata);
   modport slave  (input address, read, output waitrequest, readdata);
endinterface

// File: rtl/first_nios2_system_sysid_probe_counter.sv
// Loadable down-counter; flags the last remaining count so the owner can act on that edge.
module first_nios2_system_sysid_probe_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             last
);

   logic [WIDTH-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign last = (count == {{(WIDTH-1){1'b0}}, 1'b1});

endmodule

// File: rtl/first_nios2_system_sysid_probe.sv
// Second Avalon-MM master that reads sysid words 0 and 1 and checks them against the expected image.
module first_nios2_system_sysid_probe
   import first_nios2_system_sysid_probe_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
   parameter int          READ_LATENCY       = 0,
   parameter int          TIMEOUT_CYCLES     = 255,
   parameter int          AUTO_START         = 1
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   first_nios2_system_sysid_probe_if.master      avm,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  pass,
   output logic                                  timeout,
   output logic [31:0]                           id_value,
   output logic [31:0]                           timestamp_value
);

   localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY);

   state_t      state, state_nxt;
   logic        read_r, read_nxt;
   logic        address_r, address_nxt;
   logic        busy_nxt, done_nxt, pass_nxt, timeout_nxt;
   logic [31:0] id_nxt, ts_nxt;
   logic        armed, armed_nxt;
   logic        cmp_pending, cmp_nxt;
   logic        trigger;

   logic             cnt_load, cnt_dec, cnt_last;
   logic [CNT_W-1:0] cnt_value;

   // One counter serves both roles: stall budget while reading, latency count while waiting.
   first_nios2_system_sysid_probe_counter #(.WIDTH(CNT_W)) u_counter (
      .clock      (clock),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (cnt_value),
      .dec        (cnt_dec),
      .last       (cnt_last)
   );

   assign avm.read    = read_r;
   assign avm.address = address_r;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      read_nxt    = read_r;
      address_nxt = address_r;
      busy_nxt    = busy;
      done_nxt    = done;
      pass_nxt    = pass;
      timeout_nxt = timeout;
      id_nxt      = id_value;
      ts_nxt      = timestamp_value;
      armed_nxt   = 1'b1;
      cmp_nxt     = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      cnt_value   = TMO_LOAD;
      trigger     = !busy && (start || ((AUTO_START != 0) && !armed));

      case (state)
         ST_IDLE, ST_DONE: begin
            if (cmp_pending) begin
               // Compare runs one edge after the timestamp lands so pass and done rise together.
               done_nxt = 1'b1;
               pass_nxt = (id_value == EXPECTED_ID) && (timestamp_value == EXPECTED_TIMESTAMP);
               busy_nxt = 1'b0;
            end else if (trigger) begin
               state_nxt   = ST_RD_ID;
               read_nxt    = 1'b1;
               address_nxt = SYSID_ADDR_ID;
               busy_nxt    = 1'b1;
               done_nxt    = 1'b0;
               pass_nxt    = 1'b0;
               timeout_nxt = 1'b0;
               id_nxt      = '0;
               ts_nxt      = '0;
               cnt_load    = 1'b1;
            end
         end
         ST_RD_ID, ST_RD_TS: begin
            if (!avm.waitrequest) begin
               cnt_load = 1'b1;
               if (READ_LATENCY == 0) begin
                  if (state == ST_RD_ID) begin
                     id_nxt      = avm.readdata;
                     address_nxt = SYSID_ADDR_TS;
                     state_nxt   = ST_RD_TS;
                  end else begin
                     ts_nxt    = avm.readdata;
                     read_nxt  = 1'b0;
                     state_nxt = ST_DONE;
                     cmp_nxt   = 1'b1;
                  end
               end else begin
                  read_nxt  = 1'b0;
                  cnt_value = LAT_LOAD;
                  state_nxt = (state == ST_RD_ID) ? ST_WAIT_ID : ST_WAIT_TS;
               end
            end else if (cnt_last) begin
               read_nxt    = 1'b0;
               timeout_nxt = 1'b1;
               pass_nxt    = 1'b0;
               done_nxt    = 1'b1;
               busy_nxt    = 1'b0;
               state_nxt   = ST_DONE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_WAIT_ID: begin
            if (cnt_last) begin
               id_nxt      = avm.readdata;
               read_nxt    = 1'b1;
               address_nxt = SYSID_ADDR_TS;
               state_nxt   = ST_RD_TS;
               cnt_load    = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_WAIT_TS: begin
            if (cnt_last) begin
               ts_nxt    = avm.readdata;
               state_nxt = ST_DONE;
               cmp_nxt   = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         read_r          <= 1'b0;
         address_r       <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         pass            <= 1'b0;
         timeout         <= 1'b0;
         id_value        <= '0;
         timestamp_value <= '0;
         armed           <= 1'b0;
         cmp_pending     <= 1'b0;
      end else begin
         state           <= state_nxt;
         read_r          <= read_nxt;
         address_r       <= address_nxt;
         busy            <= busy_nxt;
         done            <= done_nxt;
         pass            <= pass_nxt;
         timeout         <= timeout_nxt;
         id_value        <= id_nxt;
         timestamp_value <= ts_nxt;
         armed           <= armed_nxt;
         cmp_pending     <= cmp_nxt;
      end
   end

endmodule

// File: tb/tb_first_nios2_system_sysid_probe.sv
// Self-checking bench: two probes (read latency 0 and 2) against behavioural sysid slaves.
module tb_first_nios2_system_sysid_probe;

   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1455298001;
   localparam int          LAT2   = 2;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset0 = 1'b1, reset2 = 1'b1, start0 = 1'b0, start2 = 1'b0;
   logic        busy0, done0, pass0, timeout0, busy2, done2, pass2, timeout2;
   logic [31:0] id0, ts0, id2, ts2;

   first_nios2_system_sysid_probe_if bus0 ();
   first_nios2_system_sysid_probe_if bus2 ();

   first_nios2_system_sysid_probe #(.READ_LATENCY(0), .TIMEOUT_CYCLES(255), .AUTO_START(1)) dut0 (
      .clock(clock), .reset(reset0), .start(start0), .avm(bus0), .busy(busy0), .done(done0),
      .pass(pass0), .timeout(timeout0), .id_value(id0), .timestamp_value(ts0));

   first_nios2_system_sysid_probe #(.READ_LATENCY(LAT2), .TIMEOUT_CYCLES(255), .AUTO_START(1)) dut2 (
      .clock(clock), .reset(reset2), .start(start2), .avm(bus2), .busy(busy2), .done(done2),
      .pass(pass2), .timeout(timeout2), .id_value(id2), .timestamp_value(ts2));

   int passed = 0;
   int total  = 0;

   // Slave models: word memory, optional stalls on word 1, or a stuck waitrequest.
   logic [31:0] mem0 [2];
   logic [31:0] mem2 [2];
   int   stall_cnt0 = 0, stall_tgt0 = 0, stall_cnt2 = 0, stall_tgt2 = 0;
   logic stuck0 = 1'b0;
   logic acc0 [$];
   logic acc2 [$];
   int   overlap2 = 0;

   assign bus0.waitrequest = stuck0 || (bus0.read && bus0.address && (stall_cnt0 < stall_tgt0));
   assign bus0.readdata    = bus0.read ? mem0[bus0.address] : 32'hDEAD_BEEF;

   always @(posedge clock) begin
      if (bus0.read && bus0.waitrequest) stall_cnt0 <= stall_cnt0 + 1;
      if (bus0.read && !bus0.waitrequest) acc0.push_back(bus0.address);
   end

   bit          pipe2_v [LAT2];
   logic [31:0] pipe2_d [LAT2];

   assign bus2.waitrequest = bus2.read && bus2.address && (stall_cnt2 < stall_tgt2);
   assign bus2.readdata    = pipe2_v[LAT2-1] ? pipe2_d[LAT2-1] : 32'hDEAD_BEEF;

   always @(posedge clock) begin
      if (bus2.read && bus2.waitrequest) stall_cnt2 <= stall_cnt2 + 1;
      if (bus2.read && !bus2.waitrequest) acc2.push_back(bus2.address);
      if (bus2.read && (pipe2_v[0] || pipe2_v[1])) overlap2 <= overlap2 + 1;
      pipe2_v[0] <= bus2.read && !bus2.waitrequest;
      pipe2_d[0] <= mem2[bus2.address];
      for (int i = 1; i < LAT2; i++) begin
         pipe2_v[i] <= pipe2_v[i-1];
         pipe2_d[i] <= pipe2_d[i-1];
      end
   end

   // Reference: each probe costs 3 edges, plus one per stall cycle and two latency waits.
   function automatic int model_edges(input int lat, input int stalls);
      return 3 + stalls + 2 * lat;
   endfunction

   function automatic bit model_pass(input logic [31:0] w0, input logic [31:0] w1);
      return (w0 == EXP_ID) && (w1 == EXP_TS);
   endfunction

   // Pulse start across one edge; returns at the negedge right after the trigger edge.
   task automatic trigger(input int d);
      @(negedge clock);
      if (d == 0) start0 = 1'b1; else start2 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      start2 = 1'b0;
   endtask

   task automatic wait_done(input int d, input int from, input int bound, output int edges);
      edges = from;
      while (((d == 0) ? done0 : done2) !== 1'b1 && edges < bound) begin
         @(negedge clock);
         edges++;
      end
   endtask

   task automatic test_reset();
      mem0[0] = EXP_ID; mem0[1] = EXP_TS;
      mem2[0] = EXP_ID; mem2[1] = EXP_TS;
      repeat (2) @(negedge clock);
      total++;
      if ({busy0, done0, pass0, timeout0, bus0.read, bus0.address, id0, ts0} !== '0)
         $display("FAIL reset_dut0: outputs=%b %h %h want all zero",
                  {busy0, done0, pass0, timeout0, bus0.read, bus0.address}, id0, ts0);
      else passed++;
      total++;
      if ({busy2, done2, pass2, timeout2, bus2.read, bus2.address, id2, ts2} !== '0)
         $display("FAIL reset_dut2: outputs=%b %h %h want all zero",
                  {busy2, done2, pass2, timeout2, bus2.read, bus2.address}, id2, ts2);
      else passed++;
   endtask

   task automatic test_auto_start();
      acc0.delete();
      @(negedge clock);
      reset0 = 1'b0;
      @(negedge clock);
      total++;
      if ({busy0, bus0.read, bus0.address} !== 3'b110)
         $display("FAIL auto_first_read: busy/read/addr=%b want 110", {busy0, bus0.read, bus0.address});
      else passed++;
      @(negedge clock);
      total++;
      if ({bus0.read, bus0.address} !== 2'b11)
         $display("FAIL auto_back_to_back: read/addr=%b want 11", {bus0.read, bus0.address});
      else passed++;
      @(negedge clock);
      total++;
      if ({busy0, done0, bus0.read} !== 3'b100)
         $display("FAIL auto_edge2: busy/done/read=%b want 100", {busy0, done0, bus0.read});
      else passed++;
      @(negedge clock);
      total++;
      if ({busy0, done0, pass0, timeout0} !== 4'b0110)
         $display("FAIL auto_done: busy/done/pass/timeout=%b want 0110", {busy0, done0, pass0, timeout0});
      else passed++;
      total++;
      if (id0 !== EXP_ID || ts0 !== EXP_TS)
         $display("FAIL auto_capture: id=%h ts=%h want %h %h", id0, ts0, EXP_ID, EXP_TS);
      else passed++;
      total++;
      if (acc0.size() != 2 || acc0[0] !== 1'b0 || acc0[1] !== 1'b1)
         $display("FAIL auto_addr_order: accepts=%0d want 2 (addr 0 then 1)", acc0.size());
      else passed++;
   endtask

   task automatic test_mismatch();
      int edges;
      mem0[0] = 32'h0000_0001;
      trigger(0);
      wait_done(0, 0, 30, edges);
      total++;
      if (edges !== model_edges(0, 0) || pass0 !== 1'b0)
         $display("FAIL mismatch_result: edges=%0d pass=%b want %0d 0", edges, pass0, model_edges(0, 0));
      else passed++;
      total++;
      if (id0 !== 32'h1 || ts0 !== EXP_TS)
         $display("FAIL mismatch_capture: id=%h ts=%h want 00000001 %h", id0, ts0, EXP_TS);
      else passed++;
      mem0[0] = EXP_ID;
   endtask

   task automatic test_stall();
      int edges = 0;
      int rd_ts = 0;
      bit dropped = 0;
      stall_tgt0 = stall_cnt0 + 3;
      trigger(0);
      while (done0 !== 1'b1 && edges < 30) begin
         if (bus0.read && bus0.address) rd_ts++;
         else if (rd_ts > 0 && !done0 && bus0.read) dropped = 1;
         @(negedge clock);
         edges++;
      end
      total++;
      if (rd_ts !== 4 || dropped)
         $display("FAIL stall_stable: addr1 read cycles=%0d want 4", rd_ts);
      else passed++;
      total++;
      if (edges !== model_edges(0, 3) || pass0 !== 1'b1)
         $display("FAIL stall_done: edges=%0d pass=%b want %0d 1", edges, pass0, model_edges(0, 3));
      else passed++;
   endtask

   task automatic test_timeout();
      int edges = 0;
      int rd_hi = 0;
      stuck0 = 1'b1;
      trigger(0);
      while (done0 !== 1'b1 && edges < 400) begin
         if (bus0.read === 1'b1 && bus0.address === 1'b0) rd_hi++;
         @(negedge clock);
         edges++;
      end
      total++;
      if (rd_hi !== 255 || bus0.read !== 1'b0)
         $display("FAIL timeout_read_cycles: got %0d read=%b want 255 0", rd_hi, bus0.read);
      else passed++;
      total++;
      if ({busy0, done0, pass0, timeout0} !== 4'b0101 || edges !== 255)
         $display("FAIL timeout_flags: busy/done/pass/timeout=%b edges=%0d want 0101 255",
                  {busy0, done0, pass0, timeout0}, edges);
      else passed++;
      stuck0 = 1'b0;
      trigger(0);
      wait_done(0, 0, 30, edges);
      total++;
      if ({pass0, timeout0} !== 2'b10)
         $display("FAIL timeout_cleared: pass/timeout=%b want 10", {pass0, timeout0});
      else passed++;
   endtask

   task automatic test_latency_auto();
      int edges;
      acc2.delete();
      @(negedge clock);
      reset2 = 1'b0;
      @(negedge clock);
      wait_done(2, 0, 40, edges);
      total++;
      if (edges !== model_edges(LAT2, 0) || pass2 !== 1'b1 || ts2 !== EXP_TS)
         $display("FAIL latency_probe: edges=%0d pass=%b ts=%h want %0d 1 %h",
                  edges, pass2, ts2, model_edges(LAT2, 0), EXP_TS);
      else passed++;
   endtask

   task automatic test_start_while_busy();
      int edges;
      acc2.delete();
      trigger(2);
      repeat (2) @(negedge clock);
      start2 = 1'b1;
      @(negedge clock);
      start2 = 1'b0;
      wait_done(2, 3, 40, edges);
      repeat (5) @(negedge clock);
      total++;
      if (edges !== model_edges(LAT2, 0) || acc2.size() != 2 || busy2 !== 1'b0)
         $display("FAIL busy_start_ignored: edges=%0d accepts=%0d busy=%b want %0d 2 0",
                  edges, acc2.size(), busy2, model_edges(LAT2, 0));
      else passed++;
      total++;
      if (overlap2 !== 0 || pass2 !== 1'b1)
         $display("FAIL single_outstanding: overlaps=%0d pass=%b want 0 1", overlap2, pass2);
      else passed++;
   endtask

   task automatic test_reset_mid_probe();
      int edges;
      mem2[0] = 32'h1234_5678;
      trigger(2);
      repeat (4) @(negedge clock);
      total++;
      if (id2 !== 32'h1234_5678 || busy2 !== 1'b1 || bus2.read !== 1'b0)
         $display("FAIL mid_probe_state: id=%h busy=%b read=%b want 12345678 1 0", id2, busy2, bus2.read);
      else passed++;
      #2 reset2 = 1'b1;
      #1;
      total++;
      if ({busy2, done2, pass2, timeout2, bus2.read, bus2.address, id2, ts2} !== '0)
         $display("FAIL mid_probe_reset: outputs=%b %h %h want all zero",
                  {busy2, done2, pass2, timeout2, bus2.read, bus2.address}, id2, ts2);
      else passed++;
      @(negedge clock);
      mem2[0] = EXP_ID;
      reset2  = 1'b0;
      @(negedge clock);
      wait_done(2, 0, 40, edges);
      total++;
      if (edges !== model_edges(LAT2, 0) || pass2 !== 1'b1)
         $display("FAIL reprobe_after_reset: edges=%0d pass=%b want %0d 1", edges, pass2, model_edges(LAT2, 0));
      else passed++;
   endtask

   task automatic test_random();
      int          edges, stalls, lat, d;
      logic [31:0] w0, w1;
      bit          exp_pass;
      for (int i = 0; i < 20; i++) begin
         d      = i % 2;
         lat    = (d == 0) ? 0 : LAT2;
         w0     = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
         w1     = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
         stalls = $urandom_range(0, 4);
         exp_pass = model_pass(w0, w1);
         if (d == 0) begin
            mem0[0] = w0; mem0[1] = w1; stall_tgt0 = stall_cnt0 + stalls;
         end else begin
            mem2[0] = w0; mem2[1] = w1; stall_tgt2 = stall_cnt2 + stalls;
         end
         trigger(d);
         wait_done(d, 0, 60, edges);
         total++;
         if (edges !== model_edges(lat, stalls))
            $display("FAIL rand_latency[%0d]: edges=%0d want %0d", i, edges, model_edges(lat, stalls));
         else passed++;
         total++;
         if (((d == 0) ? pass0 : pass2) !== exp_pass || ((d == 0) ? timeout0 : timeout2) !== 1'b0)
            $display("FAIL rand_pass[%0d]: pass=%b timeout=%b want %b 0", i,
                     (d == 0) ? pass0 : pass2, (d == 0) ? timeout0 : timeout2, exp_pass);
         else passed++;
         total++;
         if (((d == 0) ? id0 : id2) !== w0 || ((d == 0) ? ts0 : ts2) !== w1)
            $display("FAIL rand_capture[%0d]: id=%h ts=%h want %h %h", i,
                     (d == 0) ? id0 : id2, (d == 0) ? ts0 : ts2, w0, w1);
         else passed++;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_auto_start();
      test_mismatch();
      test_stall();
      test_timeout();
      test_latency_auto();
      test_start_while_busy();
      test_reset_mid_probe();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
